// File: rtl/vctrl_reg_sequencer.sv
// Write-side initiator for the vector control register file: latches one configuration
// request and writes vl (reg 0) and the matmul row/col thermometer masks (regs 31, 30, 29).
module vctrl_reg_sequencer #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int MATSIZE     = 8,
  parameter int CNTW        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_vl,
  input  logic [CNTW-1:0]        req_a_rows,
  input  logic [CNTW-1:0]        req_a_cols,
  input  logic [CNTW-1:0]        req_b_cols,
  input  logic [3:0]             req_fields,
  input  logic                   wr_grant,
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [LOG2NUMREGS-1:0] REG_VL     = '0;
  localparam logic [LOG2NUMREGS-1:0] REG_A_ROWS = {LOG2NUMREGS{1'b1}};
  localparam logic [LOG2NUMREGS-1:0] REG_A_COLS = {LOG2NUMREGS{1'b1}} - LOG2NUMREGS'(1);
  localparam logic [LOG2NUMREGS-1:0] REG_B_COLS = {LOG2NUMREGS{1'b1}} - LOG2NUMREGS'(2);

  state_t             state_q;
  logic               req_ready_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         pend_q;
  logic [3:0]         pend_d;
  logic [3:0]         cur_oh;
  logic [WIDTH-1:0]   vl_q;
  logic [MATSIZE-1:0] m_a_rows_q, m_a_cols_q, m_b_cols_q;
  logic [MATSIZE-1:0] m_a_rows_d, m_a_cols_d, m_b_cols_d;

  // Thermometer bit i is set when the count exceeds i; counts >= MATSIZE saturate to all ones.
  generate
    for (genvar gi = 0; gi < MATSIZE; gi++) begin : g_therm
      assign m_a_rows_d[gi] = (int'(req_a_rows) > gi);
      assign m_a_cols_d[gi] = (int'(req_a_cols) > gi);
      assign m_b_cols_d[gi] = (int'(req_b_cols) > gi);
    end
  endgenerate

  // Lowest-order pending field is the one currently presented on the port.
  assign cur_oh = pend_q & (~pend_q + 4'd1);

  always_comb begin
    c_reg         = '0;
    c_writedatain = '0;
    c_we          = 1'b0;
    if (state_q == WRITE) begin
      c_we = wr_grant && !reset && (pend_q != 4'd0);
      if (cur_oh[0]) begin
        c_reg         = REG_VL;
        c_writedatain = vl_q;
      end else if (cur_oh[1]) begin
        c_reg         = REG_A_ROWS;
        c_writedatain = WIDTH'(m_a_rows_q);
      end else if (cur_oh[2]) begin
        c_reg         = REG_A_COLS;
        c_writedatain = WIDTH'(m_a_cols_q);
      end else if (cur_oh[3]) begin
        c_reg         = REG_B_COLS;
        c_writedatain = WIDTH'(m_b_cols_q);
      end
    end
  end

  assign pend_d = c_we ? (pend_q & ~cur_oh) : pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= '0;
      vl_q        <= '0;
      m_a_rows_q  <= '0;
      m_a_cols_q  <= '0;
      m_b_cols_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            vl_q        <= req_vl;
            m_a_rows_q  <= m_a_rows_d;
            m_a_cols_q  <= m_a_cols_d;
            m_b_cols_q  <= m_b_cols_d;
            pend_q      <= req_fields;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_fields != 4'd0) begin
              state_q <= WRITE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          pend_q <= pend_d;
          if (pend_d == 4'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vctrl_reg_sequencer.sv
// Self-checking bench for vctrl_reg_sequencer: table of requests with constant expected masks,
// a write scoreboard fed at request time, plus hand-written stall and reset sequences.
module tb_vctrl_reg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vl;
  logic [7:0]  req_a_rows, req_a_cols, req_b_cols;
  logic [3:0]  req_fields;
  logic        wr_grant;
  logic [4:0]  c_reg;
  logic [31:0] c_writedatain;
  logic        c_we;
  logic        busy;
  logic        done;

  vctrl_reg_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_vl(req_vl), .req_a_rows(req_a_rows), .req_a_cols(req_a_cols),
    .req_b_cols(req_b_cols), .req_fields(req_fields), .wr_grant(wr_grant),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vl;
    logic [7:0]  a_rows, a_cols, b_cols;
    logic [3:0]  fields;
    logic [7:0]  m31, m30, m29;
  } vec_t;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  vec_t vecs [6];
  wr_t  exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every granted write must match the head of the expected queue.
  always @(negedge clk) begin
    if (c_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", c_reg, c_writedatain);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write reg=%0d data=%h (expected reg=%0d data=%h)", c_reg, c_writedatain, e.r, e.d);
        chk("write_reg", {27'd0, c_reg}, {27'd0, e.r});
        chk("write_data", c_writedatain, e.d);
      end
    end
  end

  task automatic push_writes(input vec_t v, input int max_writes);
    int n = 0;
    if (v.fields[0] && n < max_writes) begin exp_q.push_back('{5'd0,  v.vl});           n++; end
    if (v.fields[1] && n < max_writes) begin exp_q.push_back('{5'd31, {24'd0, v.m31}}); n++; end
    if (v.fields[2] && n < max_writes) begin exp_q.push_back('{5'd30, {24'd0, v.m30}}); n++; end
    if (v.fields[3] && n < max_writes) begin exp_q.push_back('{5'd29, {24'd0, v.m29}}); n++; end
  endtask

  task automatic drive_req(input vec_t v);
    req_vl     = v.vl;
    req_a_rows = v.a_rows;
    req_a_cols = v.a_cols;
    req_b_cols = v.b_cols;
    req_fields = v.fields;
    req_valid  = 1'b1;
  endtask

  // Runs one request; grant is withheld for stall_len cycles starting at cycle stall_from after accept.
  task automatic run_req(input vec_t v, input int stall_from, input int stall_len,
                         input logic [4:0] hold_reg, input logic [31:0] hold_data);
    int done_k = -1;
    int npend  = 0;
    for (int b = 0; b < 4; b++) if (v.fields[b]) npend++;
    push_writes(v, 4);
    @(posedge clk); #1;
    drive_req(v);
    wr_grant = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      wr_grant = !(stall_len > 0 && k >= stall_from && k < stall_from + stall_len);
      @(negedge clk);
      if (k == 1) begin
        chk("busy_in_seq", {31'd0, busy}, 32'd1);
        chk("ready_in_seq", {31'd0, req_ready}, 32'd0);
      end
      if (!wr_grant) begin
        chk("stall_we", {31'd0, c_we}, 32'd0);
        chk("stall_reg", {27'd0, c_reg}, {27'd0, hold_reg});
        chk("stall_data", c_writedatain, hold_data);
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    $display("request fields=%h vl=%h: done at cycle %0d after accept", v.fields, v.vl, done_k);
    chk("done_cycle", done_k, npend + 1 + stall_len);
    chk("writes_drained", exp_q.size(), 0);
    exp_q.delete();
    wr_grant = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'd16,       8'd3, 8'd8,   8'd5,   4'hF, 8'h07, 8'hFF, 8'h1F};
    vecs[1] = '{32'hDEADBEEF, 8'd0, 8'd200, 8'd8,   4'hE, 8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{32'h0000AAAA, 8'd4, 8'd0,   8'd2,   4'hA, 8'h0F, 8'h00, 8'h03};
    vecs[3] = '{32'h11111111, 8'd5, 8'd5,   8'd5,   4'h0, 8'h1F, 8'h1F, 8'h1F};
    vecs[4] = '{32'h12345678, 8'd1, 8'd7,   8'd255, 4'h5, 8'h01, 8'h7F, 8'hFF};
    vecs[5] = '{32'h0,        8'd9, 8'd6,   8'd1,   4'h8, 8'hFF, 8'h3F, 8'h01};

    // Reset asserted together with a valid request: reset must win.
    reset    = 1'b1;
    wr_grant = 1'b1;
    drive_req(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, c_we}, 32'd0);
    chk("rst_reg", {27'd0, c_reg}, 32'd0);
    chk("rst_data", c_writedatain, 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_req(vecs[i], 0, 0, 5'd0, 32'd0);

    // Grant withheld for 3 cycles before the second write.
    run_req(vecs[0], 2, 3, 5'd31, 32'h07);

    // Reset after the second write: remaining writes and done are dropped.
    push_writes(vecs[0], 2);
    @(posedge clk); #1;
    drive_req(vecs[0]);
    wr_grant = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset    = 1'b1;
    wr_grant = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b0;
    wr_grant = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_done", {31'd0, done}, 32'd0);
      chk("midrst_no_we", {31'd0, c_we}, 32'd0);
      @(negedge clk);
    end
    chk("midrst_two_writes", exp_q.size(), 0);
    exp_q.delete();
    $display("reset mid-sequence checked");

    run_req(vecs[0], 0, 0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
